// File: rtl/count_monitor_pkg.sv
// Shared state encoding for the count monitor FSM; the bench imports it to decode state.
package count_monitor_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

endpackage

// File: rtl/count_monitor_sat_counter.sv
// Saturating event counter with synchronous clear; a clear and an increment in the
// same cycle leave the count at one (clear first, then count the new event).
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = i_inc ? WIDTH'(1) : '0;
        end else if (i_inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/count_monitor.sv
// Receive-side monitor for an incrementing count: locks after LOCK_CNT good steps,
// then flags and counts every step that is not previous + 1 (mod 2^WIDTH).
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_sample_en,
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_clr_err,
    output logic             o_locked,
    output logic             o_err,
    output logic [ERR_W-1:0] o_err_count,
    output logic [WIDTH-1:0] o_last
);

    localparam int MW = $clog2(LOCK_CNT + 1);

    state_e           state_q;
    logic [MW-1:0]    match_q;
    logic             locked_q;
    logic             err_q;
    logic [WIDTH-1:0] last_q;

    logic [WIDTH-1:0] exp_next;
    logic             step_good;
    logic             err_inc;

    assign exp_next  = last_q + WIDTH'(1);
    assign step_good = (i_count == exp_next);
    assign err_inc   = i_sample_en && (state_q == ST_LOCKED) && !step_good;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_SEARCH;
            match_q  <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            last_q   <= '0;
        end else begin
            err_q <= 1'b0;
            // Every sample re-syncs the reference, whatever the state.
            if (i_sample_en) begin
                last_q <= i_count;
            end
            case (state_q)
                ST_SEARCH: begin
                    if (i_sample_en) begin
                        match_q <= '0;
                        state_q <= ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (i_sample_en) begin
                        if (!step_good) begin
                            match_q <= '0;
                        end else if (match_q == MW'(LOCK_CNT - 1)) begin
                            match_q  <= '0;
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                        end else begin
                            match_q <= match_q + MW'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    if (i_sample_en && !step_good) begin
                        err_q    <= 1'b1;
                        match_q  <= '0;
                        state_q  <= ST_ACQUIRE;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_SEARCH;
                    match_q  <= '0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH(ERR_W)
    ) u_err_cnt (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_clr  (i_clr_err),
        .i_inc  (err_inc),
        .count  (o_err_count)
    );

    assign o_locked = locked_q;
    assign o_err    = err_q;
    assign o_last   = last_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: lock acquisition, wrap, error pulses, gaps,
// error-counter saturation and clear, and reset in the middle of lock.
module tb_count_monitor;
    import count_monitor_pkg::*;

    logic       clk;
    logic       rst;
    logic       sample_en;
    logic [7:0] count;
    logic       clr_err;
    logic       locked;
    logic       err;
    logic [7:0] err_count;
    logic [7:0] last;

    int tests;
    int fails;
    logic [7:0] cur;
    int exp_cnt;

    count_monitor #(
        .WIDTH(8),
        .LOCK_CNT(4),
        .ERR_W(8)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_sample_en(sample_en),
        .i_count    (count),
        .i_clr_err  (clr_err),
        .o_locked   (locked),
        .o_err      (err),
        .o_err_count(err_count),
        .o_last     (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic [7:0] v, input logic clr);
        @(negedge clk);
        rst       = r;
        sample_en = en;
        count     = v;
        clr_err   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic samp(input logic [7:0] v);
        step(1'b0, 1'b1, v, 1'b0);
        cur = v;
    endtask

    // Four good steps from the current value: ends locked.
    task automatic relock();
        for (int k = 0; k < 4; k++) samp(cur + 8'd1);
    endtask

    initial begin
        tests = 0; fails = 0; cur = 8'h00; exp_cnt = 0;
        rst = 1'b1; sample_en = 1'b0; count = 8'h00; clr_err = 1'b0;

        // Reset
        step(1'b1, 1'b1, 8'hAA, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_errcnt", 32'(err_count), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(ST_SEARCH));

        // 1: 0x10..0x14 locks after the fourth good step
        samp(8'h10);
        check("t1_acq_state", 32'(dut.state_q), 32'(ST_ACQUIRE));
        samp(8'h11); samp(8'h12); samp(8'h13);
        check("t1_not_yet", 32'(locked), 32'd0);
        check("t1_no_err", 32'(err), 32'd0);
        samp(8'h14);
        check("t1_locked", 32'(locked), 32'd1);
        check("t1_last", 32'(last), 32'h14);
        check("t1_errcnt", 32'(err_count), 32'd0);

        // 2: wrap through 0xFF -> 0x00 is a good step
        step(1'b1, 1'b0, 8'h00, 1'b0);
        samp(8'hFA); relock();
        check("t2_locked_fe", 32'(locked), 32'd1);
        samp(8'hFF); samp(8'h00);
        check("t2_wrap_err", 32'(err), 32'd0);
        samp(8'h01);
        check("t2_locked", 32'(locked), 32'd1);
        check("t2_errcnt", 32'(err_count), 32'd0);
        check("t2_last", 32'(last), 32'h01);

        // 3: step error while locked, then relock
        step(1'b1, 1'b0, 8'h00, 1'b0);
        samp(8'h2C); relock();
        check("t3_locked30", 32'(locked), 32'd1);
        samp(8'h35);
        check("t3_err", 32'(err), 32'd1);
        check("t3_errcnt", 32'(err_count), 32'd1);
        check("t3_unlocked", 32'(locked), 32'd0);
        check("t3_last", 32'(last), 32'h35);
        samp(8'h36);
        check("t3_err_pulse", 32'(err), 32'd0);
        samp(8'h37); samp(8'h38);
        check("t3_not_yet", 32'(locked), 32'd0);
        samp(8'h39);
        check("t3_relock", 32'(locked), 32'd1);
        check("t3_errcnt_hold", 32'(err_count), 32'd1);

        // 4: gaps in sampling, then a repeated value
        for (int k = 0; k < 7; k++) samp(cur + 8'd1);
        check("t4_at40", 32'(last), 32'h40);
        step(1'b0, 1'b0, 8'h99, 1'b0);
        step(1'b0, 1'b0, 8'h55, 1'b0);
        check("t4_gap_last", 32'(last), 32'h40);
        check("t4_gap_locked", 32'(locked), 32'd1);
        samp(8'h41);
        check("t4_gap_good", 32'(err), 32'd0);
        check("t4_gap_lock", 32'(locked), 32'd1);
        samp(8'h41);
        check("t4_repeat_err", 32'(err), 32'd1);
        check("t4_repeat_cnt", 32'(err_count), 32'd2);
        check("t4_repeat_unlock", 32'(locked), 32'd0);

        // 5: saturation of the error counter
        exp_cnt = 2;
        for (int n = 0; n < 300; n++) begin
            relock();
            samp(cur);
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            check("t5_errcnt", 32'(err_count), 32'(exp_cnt));
        end
        check("t5_sat_err", 32'(err), 32'd1);
        check("t5_sat", 32'(err_count), 32'hFF);
        relock();
        step(1'b0, 1'b1, cur + 8'd7, 1'b1);
        cur = cur + 8'd7;
        check("t5_clr_with_err", 32'(err_count), 32'd1);
        check("t5_clr_err_pulse", 32'(err), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("t5_clr_alone", 32'(err_count), 32'd0);
        check("t5_clr_state", 32'(dut.state_q), 32'(ST_ACQUIRE));

        // 6: reset in the middle of lock
        relock();
        samp(cur + 8'd3);
        relock();
        check("t6_pre_locked", 32'(locked), 32'd1);
        check("t6_pre_errcnt", 32'(err_count), 32'd1);
        step(1'b1, 1'b1, cur + 8'd1, 1'b0);
        check("t6_locked", 32'(locked), 32'd0);
        check("t6_errcnt", 32'(err_count), 32'd0);
        check("t6_last", 32'(last), 32'd0);
        check("t6_state", 32'(dut.state_q), 32'(ST_SEARCH));
        samp(8'h77);
        check("t6_first_err", 32'(err), 32'd0);
        check("t6_first_state", 32'(dut.state_q), 32'(ST_ACQUIRE));
        samp(8'h90);
        check("t6_acq_bad_err", 32'(err), 32'd0);
        check("t6_acq_bad_cnt", 32'(err_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
